// File: rtl/exp5_detector_jogada.sv
// Play detector: synchronises and debounces the buttons, emits one 'jogada' pulse per one-hot press, and re-arms after a debounced release.
// Optional MULTI_PRESS_ERR_EN: a stable multi-button press drops to SOLTA with a one-cycle 'multipla' pulse.
module exp5_detector_jogada #(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CICLOS = 20
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic                habilita,
   input  logic                zera,
   output logic                jogada,
   output logic [N_BOTOES-1:0] botao_reg,
   output logic                multipla,
   output logic [3:0]          db_estado_det
);
   localparam int CNT_W = $clog2(DEBOUNCE_CICLOS);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CICLOS - 1);

   typedef enum logic [1:0] {
      OCIOSO      = 2'd0,
      FILTRA      = 2'd1,
      PRESSIONADO = 2'd2,
      SOLTA       = 2'd3
   } estado_t;

   estado_t             estado, estado_prox;
   logic [N_BOTOES-1:0] sync1, b_s;
   logic [N_BOTOES-1:0] cap, cap_prox;
   logic [CNT_W-1:0]    cnt, cnt_prox;
   logic                captura;
   logic                um_quente;
`ifdef MULTI_PRESS_ERR_EN
   logic                multi_prox;
   logic                multipla_r;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         b_s   <= '0;
      end else begin
         sync1 <= botoes;
         b_s   <= sync1;
      end
   end

   assign um_quente = (cap != '0) && ((cap & (cap - N_BOTOES'(1))) == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= OCIOSO;
         cap    <= '0;
         cnt    <= '0;
      end else begin
         estado <= estado_prox;
         cap    <= cap_prox;
         cnt    <= cnt_prox;
      end
   end

   always_comb begin
      estado_prox = estado;
      cap_prox    = cap;
      cnt_prox    = cnt;
      captura     = 1'b0;
`ifdef MULTI_PRESS_ERR_EN
      multi_prox  = 1'b0;
`endif
      case (estado)
         OCIOSO: begin
            if (b_s != '0) begin
               estado_prox = FILTRA;
               cap_prox    = b_s;
               cnt_prox    = '0;
            end
         end
         FILTRA: begin
            if (b_s == '0) begin
               estado_prox = OCIOSO;
            end else if (b_s != cap) begin
               cap_prox = b_s;
               cnt_prox = '0;
            end else if (cnt == TERMINAL) begin
               // a stable multi-press without the error feature just parks here
               if (um_quente) begin
                  estado_prox = PRESSIONADO;
                  captura     = 1'b1;
               end
`ifdef MULTI_PRESS_ERR_EN
               else begin
                  estado_prox = SOLTA;
                  cnt_prox    = '0;
                  multi_prox  = 1'b1;
               end
`endif
            end else begin
               cnt_prox = cnt + CNT_W'(1);
            end
         end
         PRESSIONADO: begin
            estado_prox = SOLTA;
            cnt_prox    = '0;
         end
         SOLTA: begin
            if (b_s != '0) begin
               cnt_prox = '0;
            end else if (cnt == TERMINAL) begin
               estado_prox = OCIOSO;
            end else begin
               cnt_prox = cnt + CNT_W'(1);
            end
         end
         default: estado_prox = OCIOSO;
      endcase
   end

   // capture on the edge entering PRESSIONADO takes priority over zera
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         botao_reg <= '0;
      end else if (captura && habilita) begin
         botao_reg <= cap;
      end else if (zera) begin
         botao_reg <= '0;
      end
   end

`ifdef MULTI_PRESS_ERR_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         multipla_r <= 1'b0;
      end else begin
         multipla_r <= multi_prox;
      end
   end
   assign multipla = multipla_r;
`else
   assign multipla = 1'b0;
`endif

   assign jogada = (estado == PRESSIONADO) && habilita;

   always_comb begin
      case (estado)
         OCIOSO:      db_estado_det = 4'h0;
         FILTRA:      db_estado_det = 4'h1;
         PRESSIONADO: db_estado_det = 4'h2;
         SOLTA:       db_estado_det = 4'h3;
         default:     db_estado_det = 4'hF;
      endcase
   end
endmodule

// File: tb/tb_exp5_detector_jogada.sv
// Bench for exp5_detector_jogada with DEBOUNCE_CICLOS=4: directed scenarios, then random button traffic against a run-length model.
module tb_exp5_detector_jogada;
   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] botoes;
   logic       habilita;
   logic       zera;
   logic       jogada;
   logic [3:0] botao_reg;
   logic       multipla;
   logic [3:0] db_estado_det;

   exp5_detector_jogada #(.N_BOTOES(4), .DEBOUNCE_CICLOS(D)) dut (
      .clock(clock), .reset(reset), .botoes(botoes), .habilita(habilita), .zera(zera),
      .jogada(jogada), .botao_reg(botao_reg), .multipla(multipla), .db_estado_det(db_estado_det)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc, jog_cnt, mul_cnt, jog_at;
   logic [3:0] db_h [0:63];

   // Reference model: the play fires when the synchronised vector has held the same
   // non-zero one-hot value for D+1 consecutive edges while armed; it re-arms after
   // D consecutive zero samples, ignoring the edge that follows a play.
   logic [3:0] m_d1, m_d2, m_last, m_breg;
   int         m_run, m_zrun;
   bit         m_armed, m_skip, m_jog, m_mul;

   task automatic model_reset();
      m_d1 = '0; m_d2 = '0; m_last = '0; m_breg = '0;
      m_run = 0; m_zrun = 0; m_armed = 1; m_skip = 0; m_jog = 0; m_mul = 0;
   endtask

   task automatic model_edge(input logic [3:0] raw, input logic hab, input logic z);
      logic [3:0] s;
      bit cap_now;
      s = m_d2; m_d2 = m_d1; m_d1 = raw;
      m_jog = 0; m_mul = 0; cap_now = 0;
      if (s == m_last) m_run++; else m_run = 1;
      m_last = s;
      if (m_skip) begin
         m_skip = 0;
      end else if (!m_armed) begin
         if (s == 4'd0) m_zrun++; else m_zrun = 0;
         if (m_zrun == D) m_armed = 1;
      end else if (s != 4'd0 && m_run >= D + 1) begin
         if ($countones(s) == 1) begin
            m_jog = hab;
            if (hab) begin m_breg = s; cap_now = 1; end
            m_armed = 0; m_skip = 1; m_zrun = 0;
         end
`ifdef MULTI_PRESS_ERR_EN
         else begin
            m_mul = 1; m_armed = 0; m_zrun = 0;
         end
`endif
      end
      if (z && !cap_now) m_breg = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // called at a negedge: drive, clock once, compare at the following negedge
   task automatic step(input logic [3:0] raw, input logic hab, input logic z);
      botoes = raw; habilita = hab; zera = z;
      @(posedge clock);
      model_edge(raw, hab, z);
      @(negedge clock);
      chk("jogada", jogada, m_jog);
      chk("multipla", multipla, m_mul);
      chk("botao_reg", botao_reg, m_breg);
      cyc++;
      if (cyc < 64) db_h[cyc] = db_estado_det;
      if (jogada === 1'b1) begin jog_cnt++; jog_at = cyc; end
      if (multipla === 1'b1) mul_cnt++;
   endtask

   task automatic clr();
      cyc = 0; jog_cnt = 0; mul_cnt = 0; jog_at = -1;
   endtask

   task automatic hold(input logic [3:0] raw, input logic hab, input int n);
      for (int i = 0; i < n; i++) step(raw, hab, 1'b0);
   endtask

   initial begin
      logic [3:0] v;
      logic       h;
      int         len, r;

      reset = 1'b1; botoes = '0; habilita = 1'b0; zera = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      chk("rst_db", db_estado_det, 0);
      chk("rst_jogada", jogada, 0);
      chk("rst_multipla", multipla, 0);
      chk("rst_botao_reg", botao_reg, 0);
      reset = 1'b0;

      // 1: clean press, latency D+3 and state walk
      clr();
      hold(4'b0010, 1'b1, 20);
      chk("t1_jog_cnt", jog_cnt, 1);
      chk("t1_jog_at", jog_at, 7);
      chk("t1_breg", botao_reg, 4'b0010);
      chk("t1_db2", db_h[2], 0);
      chk("t1_db3", db_h[3], 1);
      chk("t1_db7", db_h[7], 2);
      chk("t1_db8", db_h[8], 3);
      hold(4'b0000, 1'b1, 10);

      // 2: bouncing press, one play 7 edges after the final stable edge
      clr();
      for (int i = 0; i < 10; i++) step(((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
      hold(4'b0001, 1'b1, 15);
      chk("t2_jog_cnt", jog_cnt, 1);
      chk("t2_jog_at", jog_at, 15);
      chk("t2_breg", botao_reg, 4'b0001);
      hold(4'b0000, 1'b1, 10);

      // 3: long hold, short release does not re-arm, full release does
      clr();
      hold(4'b0100, 1'b1, 50);
      chk("t3_hold_cnt", jog_cnt, 1);
      clr();
      hold(4'b0000, 1'b1, 2);
      hold(4'b0100, 1'b1, 10);
      chk("t3_short_rel", jog_cnt, 0);
      clr();
      hold(4'b0000, 1'b1, 8);
      hold(4'b0100, 1'b1, 10);
      chk("t3_rearm", jog_cnt, 1);
      hold(4'b0000, 1'b1, 8);

      // 4: disabled play, then zera
      clr();
      hold(4'b1000, 1'b0, 10);
      chk("t4_jog_cnt", jog_cnt, 0);
      chk("t4_breg", botao_reg, 4'b0100);
      chk("t4_db", db_estado_det, 3);
      hold(4'b0000, 1'b0, 8);
      step(4'b0000, 1'b0, 1'b1);
      chk("t4_zera", botao_reg, 0);

      // 5: multi-button press
      clr();
      hold(4'b0011, 1'b1, 10);
      chk("t5_jog_cnt", jog_cnt, 0);
`ifdef MULTI_PRESS_ERR_EN
      chk("t5_mul_cnt", mul_cnt, 1);
      chk("t5_db", db_estado_det, 3);
`else
      chk("t5_mul_cnt", mul_cnt, 0);
      chk("t5_db", db_estado_det, 1);
`endif
      hold(4'b0000, 1'b1, 8);

      // 6: asynchronous reset mid-filter
      hold(4'b0001, 1'b1, 10);
      hold(4'b0000, 1'b1, 8);
      chk("t6_breg_pre", botao_reg, 4'b0001);
      clr();
      hold(4'b0100, 1'b1, 4);
      chk("t6_db_pre", db_estado_det, 1);
      reset = 1'b1;
      #1;
      chk("t6_db", db_estado_det, 0);
      chk("t6_breg", botao_reg, 0);
      chk("t6_jogada", jogada, 0);
      model_reset();
      @(negedge clock);
      botoes = '0;
      reset = 1'b0;

      // random traffic: segments of one vector, occasional habilita flips and zera pulses
      h = 1'b1;
      for (int seg = 0; seg < 300; seg++) begin
         r = $urandom_range(0, 9);
         if (r <= 2) v = 4'b0000;
         else if (r <= 7) v = 4'(1 << $urandom_range(0, 3));
         else begin
            v = 4'b0011;
            for (int k = 0; k < 8; k++) begin
               v = 4'($urandom_range(3, 15));
               if ($countones(v) >= 2) break;
            end
            if ($countones(v) < 2) v = 4'b0011;
         end
         if ($urandom_range(0, 4) == 0) h = ~h;
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) step(v, h, ($urandom_range(0, 19) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
